// File: rtl/data_mem_ctrl_pkg.sv
// rtl/data_mem_ctrl_pkg.sv - shared system parameters and control types for the data memory controller
package data_mem_ctrl_pkg;

    // System-wide address map and memory geometry defaults
    localparam int SYS_ADDR_WIDTH = 32;
    localparam int SYS_DATA_WIDTH = 32;
    localparam int SYS_MEM_DEPTH  = 1024;
    localparam int SYS_SEL_WIDTH  = 4;
    localparam int MEM_SEL_VALUE  = 0;

    // Controller states: INIT sweeps the array, RUN serves requests
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/mem_array_be.sv
// rtl/mem_array_be.sv - single-port word memory with byte-lane write strobes and registered read
module mem_array_be #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    parameter int IDX_W      = $clog2(MEM_DEPTH)
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic                    re,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [IDX_W-1:0]        idx,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Byte-lane write and registered read; no reset so preloaded contents survive
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) begin
                    mem_q[idx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
        if (re) begin
            rdata_q <= mem_q[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - decoded, pipelined data memory controller; optional MEM_CLEAR_ON_RESET_EN zero-fill on reset
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = SYS_ADDR_WIDTH,
    parameter int DATA_WIDTH = SYS_DATA_WIDTH,
    parameter int MEM_DEPTH  = SYS_MEM_DEPTH,
    parameter int RD_LATENCY = 1,
    parameter int SEL_WIDTH  = SYS_SEL_WIDTH,
    parameter int SEL_VALUE  = MEM_SEL_VALUE
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    WE,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wrt_data,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    data_valid,
    output logic                    err
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(MEM_DEPTH);

    localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = (ONE << OFF_W) - ONE;
    // Address bits above the word index but below the select field must be zero
    localparam logic [ADDR_WIDTH-1:0] HI_MASK  =
        (ONE << (ADDR_WIDTH - SEL_WIDTH)) - (ONE << (OFF_W + IDX_W));

    ctrl_state_e state_q, state_d;

    logic                  sel;
    logic                  accept;
    logic                  bad_addr;
    logic                  init_wr;
    logic [IDX_W-1:0]      init_idx;
    logic                  mem_we;
    logic                  mem_re;
    logic [NB-1:0]         mem_be;
    logic [IDX_W-1:0]      mem_idx;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [DATA_WIDTH-1:0] dat_out;

    logic [RD_LATENCY-1:0] vld_q;
    logic [RD_LATENCY-1:0] err_q;
    logic [RD_LATENCY-1:0] rd_q;

    assign sel      = (addr[ADDR_WIDTH-1 -: SEL_WIDTH] == SEL_WIDTH'(SEL_VALUE));
    assign accept   = req_valid && req_ready && sel;
    assign bad_addr = |(addr & (OFF_MASK | HI_MASK));

    // State register; the clear build starts in INIT, otherwise straight to RUN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
`ifdef MEM_CLEAR_ON_RESET_EN
            state_q <= ST_INIT;
`else
            state_q <= ST_RUN;
`endif
        end else begin
            state_q <= state_d;
        end
    end

`ifdef MEM_CLEAR_ON_RESET_EN
    logic [IDX_W-1:0] init_cnt_q, init_cnt_d;

    // Init word counter, restarted from word 0 by every reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            init_cnt_q <= '0;
        end else begin
            init_cnt_q <= init_cnt_d;
        end
    end

    // Next state: INIT leaves after the last word is cleared, RUN is terminal
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (state_q == ST_INIT) begin
            init_cnt_d = init_cnt_q + IDX_W'(1);
            if (init_cnt_q == IDX_W'(MEM_DEPTH - 1)) begin
                state_d = ST_RUN;
            end
        end
    end

    // Outputs: INIT owns the memory port and writes zeros
    always_comb begin
        init_wr  = (state_q == ST_INIT);
        init_idx = init_cnt_q;
    end
`else
    // Next state: without zero-fill the controller only ever runs
    always_comb begin
        state_d = ST_RUN;
    end

    // Outputs: no init sweep in this build
    always_comb begin
        init_wr  = 1'b0;
        init_idx = '0;
    end
`endif

    // Ready only in RUN and drops combinationally while reset is held
    assign req_ready = (state_q == ST_RUN) && reset;

    // Memory port steering between init sweep and accepted requests
    always_comb begin
        mem_we    = init_wr || (accept && WE && !bad_addr);
        mem_re    = accept && !WE && !bad_addr;
        mem_be    = init_wr ? {NB{1'b1}} : byte_en;
        mem_idx   = init_wr ? init_idx : addr[OFF_W +: IDX_W];
        mem_wdata = init_wr ? '0 : wrt_data;
    end

    mem_array_be #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .IDX_W      (IDX_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .re    (mem_re),
        .be    (mem_be),
        .idx   (mem_idx),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    // Response control pipeline; reset flushes everything in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
            err_q <= '0;
            rd_q  <= '0;
        end else begin
            vld_q[0] <= accept;
            err_q[0] <= accept && bad_addr;
            rd_q[0]  <= accept && !WE && !bad_addr;
            for (int k = 1; k < RD_LATENCY; k++) begin
                vld_q[k] <= vld_q[k-1];
                err_q[k] <= err_q[k-1];
                rd_q[k]  <= rd_q[k-1];
            end
        end
    end

    // The memory read register is the first data stage; extra stages delay it to match
    if (RD_LATENCY == 1) begin : g_lat1
        assign dat_out = mem_rdata;
    end else begin : g_latn
        logic [DATA_WIDTH-1:0] dat_q [RD_LATENCY-1];

        // Read data delay line; outputs are masked by the control pipe so no reset needed
        always_ff @(posedge clk) begin
            dat_q[0] <= mem_rdata;
            for (int k = 1; k < RD_LATENCY - 1; k++) begin
                dat_q[k] <= dat_q[k-1];
            end
        end

        assign dat_out = dat_q[RD_LATENCY-2];
    end

    assign data_valid = vld_q[RD_LATENCY-1];
    assign err        = err_q[RD_LATENCY-1];
    assign rd_data    = rd_q[RD_LATENCY-1] ? dat_out : '0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - table-driven scoreboard bench for data_mem_ctrl (honours MEM_CLEAR_ON_RESET_EN)
module tb_data_mem_ctrl;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        WE = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wrt_data = '0;
    logic [3:0]  byte_en = '0;
    logic [31:0] rd_data;
    logic        data_valid;
    logic        err;

    data_mem_ctrl #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MEM_DEPTH  (1024),
        .RD_LATENCY (LAT),
        .SEL_WIDTH  (4),
        .SEL_VALUE  (0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .WE         (WE),
        .addr       (addr),
        .wrt_data   (wrt_data),
        .byte_en    (byte_en),
        .rd_data    (rd_data),
        .data_valid (data_valid),
        .err        (err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic [31:0] data;
        int unsigned cyc;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        resp;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vt[21];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (data_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_data_valid", 64'd1, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("rsp_cycle", 64'(cyc), 64'(mon_e.cyc));
                    check("rsp_err", 64'(err), 64'(mon_e.err));
                    check("rsp_data", 64'(rd_data), 64'(mon_e.data));
                end
            end else begin
                check("idle_outputs_zero", {31'd0, err, rd_data}, 64'd0);
            end
        end
    end

    task automatic drive(input vec_t v);
        @(negedge clk);
        req_valid = 1'b1;
        WE        = v.we;
        addr      = v.addr;
        wrt_data  = v.data;
        byte_en   = v.be;
        check("req_ready_run", 64'(req_ready), 64'd1);
        if (v.resp) sb.push_back('{v.err, v.rdata, cyc + LAT});
    endtask

    task automatic idle_drain();
        @(negedge clk);
        req_valid = 1'b0;
        WE        = 1'b0;
        for (int k = 0; k < LAT + 10 && sb.size() != 0; k++) @(negedge clk);
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic rd(input logic [31:0] a, input logic e, input logic [31:0] d);
        drive('{1'b0, a, 32'h0, 4'h0, 1'b1, e, d});
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        drive('{1'b1, a, d, be, 1'b1, 1'b0, 32'h0});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        //          we    addr           data           be    resp  err   rdata
        vt[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0, 32'h0};
        vt[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 1'b1, 1'b0, 32'hDEAD_BEEF};
        vt[2]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 1'b1, 1'b0, 32'h0};
        vt[3]  = '{1'b1, 32'h0000_0020, 32'h0000_00AA, 4'h1, 1'b1, 1'b0, 32'h0};
        vt[4]  = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 1'b1, 1'b0, 32'h1122_33AA};
        vt[5]  = '{1'b0, 32'h0000_0012, 32'h0,         4'h0, 1'b1, 1'b1, 32'h0};
        vt[6]  = '{1'b0, 32'h0000_1000, 32'h0,         4'h0, 1'b1, 1'b1, 32'h0};
        vt[7]  = '{1'b1, 32'h0000_0000, 32'h55AA_55AA, 4'hF, 1'b1, 1'b0, 32'h0};
        vt[8]  = '{1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b1, 32'h0};
        vt[9]  = '{1'b1, 32'h0000_0012, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b1, 32'h0};
        vt[10] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 1'b1, 1'b0, 32'h55AA_55AA};
        vt[11] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 1'b1, 1'b0, 32'hDEAD_BEEF};
        vt[12] = '{1'b1, 32'h0000_0030, 32'h0000_0000, 4'hF, 1'b1, 1'b0, 32'h0};
        vt[13] = '{1'b1, 32'h0000_0030, 32'hCAFE_F00D, 4'hA, 1'b1, 1'b0, 32'h0};
        vt[14] = '{1'b0, 32'h0000_0030, 32'h0,         4'h0, 1'b1, 1'b0, 32'hCA00_F000};
        vt[15] = '{1'b0, 32'h1000_0010, 32'h0,         4'h0, 1'b0, 1'b0, 32'h0};
        vt[16] = '{1'b1, 32'h1000_0020, 32'h0000_0000, 4'hF, 1'b0, 1'b0, 32'h0};
        vt[17] = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 1'b1, 1'b0, 32'h1122_33AA};
        vt[18] = '{1'b0, 32'h0FFF_F000, 32'h0,         4'h0, 1'b1, 1'b1, 32'h0};
        vt[19] = '{1'b1, 32'h0000_0FFC, 32'h0BAD_CAFE, 4'hF, 1'b1, 1'b0, 32'h0};
        vt[20] = '{1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 1'b1, 1'b0, 32'h0BAD_CAFE};

        // Reset values while held
        #1;
        check("reset_req_ready", 64'(req_ready), 64'd0);
        check("reset_data_valid", 64'(data_valid), 64'd0);
        check("reset_rd_data", 64'(rd_data), 64'd0);
        check("reset_err", 64'(err), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

`ifdef MEM_CLEAR_ON_RESET_EN
        n = 0;
        while (!req_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("init_ready_low_cycles", 64'(n), 64'd1024);
`else
        #1;
        check("ready_first_cycle", 64'(req_ready), 64'd1);
`endif

        // Table vectors applied back-to-back
        for (int i = 0; i < 21; i++) drive(vt[i]);
        idle_drain();

        // Eight back-to-back reads after filling eight words
        for (int i = 0; i < 8; i++) wr(32'h40 + 32'(i * 4), 32'hA500_0000 + 32'(i), 4'hF);
        for (int i = 0; i < 8; i++) rd(32'h40 + 32'(i * 4), 1'b0, 32'hA500_0000 + 32'(i));
        idle_drain();

        // Reset with two reads in flight
        rd(32'h10, 1'b0, 32'hDEAD_BEEF);
        rd(32'h20, 1'b0, 32'h1122_33AA);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        req_valid = 1'b0;
        sb.delete();
        #1;
        check("midreset_req_ready", 64'(req_ready), 64'd0);
        check("midreset_data_valid", 64'(data_valid), 64'd0);
        check("midreset_rd_data", 64'(rd_data), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

`ifdef MEM_CLEAR_ON_RESET_EN
        n = 0;
        while (!req_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("reinit_ready_low_cycles", 64'(n), 64'd1024);
        for (int i = 0; i < 1024; i++) rd(32'(i * 4), 1'b0, 32'h0);
        idle_drain();
`else
        #1;
        check("rerelease_ready", 64'(req_ready), 64'd1);
        repeat (LAT + 4) @(negedge clk);
        rd(32'h10, 1'b0, 32'hDEAD_BEEF);
        rd(32'hFFC, 1'b0, 32'h0BAD_CAFE);
        idle_drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The block SHALL take parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 The block SHALL take parameter DATA_WIDTH, default 32, word width; a multiple of 8.
REQ-003 The block SHALL take parameter MEM_DEPTH, default 1024, number of words.
REQ-004 The block SHALL take parameter RD_LATENCY, default 1, accept-to-response cycles, legal range 1..4.
REQ-005 The block SHALL take parameters SEL_WIDTH, default 4, and SEL_VALUE, default 0, for the addr[ADDR_WIDTH-1 -: SEL_WIDTH] decode window.
REQ-006 The block SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-007 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-008 The block SHALL have ports req_valid (in, 1), req_ready (out, 1), WE (in, 1, 1=write), addr (in, ADDR_WIDTH, byte address).
REQ-009 The block SHALL have ports wrt_data (in, DATA_WIDTH) and byte_en (in, DATA_WIDTH/8, lane write strobes).
REQ-010 The block SHALL have ports rd_data (out, DATA_WIDTH), data_valid (out, 1, read/write completion) and err (out, 1, qualified by data_valid).

Function
REQ-011 sel SHALL be addr[ADDR_WIDTH-1 -: SEL_WIDTH]==SEL_VALUE; a request SHALL be accepted when req_valid && req_ready && sel; requests with !sel SHALL be ignored, with no response.
REQ-012 Word index SHALL be addr[log2(DATA_WIDTH/8) +: log2(MEM_DEPTH)].
REQ-013 An accepted request SHALL be erroneous when the addr byte-offset bits are nonzero or the bits between the index and the sel field are nonzero (out of range).
REQ-014 An erroneous request SHALL NOT modify memory; its response SHALL have err=1 and rd_data=0.
REQ-015 An accepted write SHALL update only the bytes whose byte_en bit is 1, on the accept edge.
REQ-016 Each accepted request SHALL produce exactly one data_valid pulse exactly RD_LATENCY cycles after acceptance; reads carry the word in rd_data; writes carry rd_data=0.
REQ-017 Responses SHALL be pipelined: one request SHALL be accepted per cycle, and responses SHALL return in order, back-to-back.
REQ-018 rd_data and err SHALL be 0 whenever data_valid=0; there SHALL be no tri-state outputs.
REQ-019 Read-after-write to the same word on the next cycle SHALL return the written data.
REQ-020 Control FSM states SHALL be INIT and RUN; req_ready SHALL be 1 only in RUN.
REQ-021 INIT SHALL step a word counter from 0 to MEM_DEPTH-1, one word per cycle, then move to RUN; RUN SHALL be held until reset.

Reset
REQ-022 Asserting reset SHALL immediately force req_ready=0, data_valid=0, rd_data=0, err=0, flush the response pipeline and zero the init counter.
REQ-023 Reset asserted mid-operation SHALL discard every in-flight response; no data_valid SHALL follow release.
REQ-024 Reset asserted during INIT SHALL restart INIT from word 0.
REQ-025 After release the FSM SHALL enter INIT when MEM_CLEAR_ON_RESET_EN is defined, otherwise RUN.

Configuration
REQ-026 With MEM_CLEAR_ON_RESET_EN defined, INIT SHALL write 0 to every word, holding req_ready=0 for MEM_DEPTH cycles after reset release.
REQ-027 Without MEM_CLEAR_ON_RESET_EN, INIT logic SHALL be absent, memory preload contents SHALL survive reset, and req_ready SHALL be 1 on the first cycle after release.

Structure
REQ-028 The shared system parameter package SHALL hold the SEL field width, the memory select value and the default ADDR/DATA widths and depth.
REQ-029 Storage SHALL be a sub-module mem_array_be: single port, byte-enable write, registered read, parametrised by DATA_WIDTH and MEM_DEPTH.
REQ-030 The latency pipeline, FSM and decode SHALL live in data_mem_ctrl.

Verification
REQ-031 Scenario: write 0xDEADBEEF with byte_en=0xF at 0x00000010, then read 0x10 -> data_valid RD_LATENCY cycles after each; read rd_data=0xDEADBEEF, err=0.
REQ-032 Scenario: write 0x000000AA with byte_en=0x1 over 0x11223344, then read -> 0x112233AA.
REQ-033 Scenario: read at 0x00000012 (misaligned) and at 0x00001000 with MEM_DEPTH=1024 (out of range) -> err=1, rd_data=0, memory unchanged.
REQ-034 Scenario: RD_LATENCY=3 with 8 back-to-back reads -> 8 consecutive data_valid pulses, in order, the first 3 cycles after the first accept.
REQ-035 Scenario: request with sel!=SEL_VALUE -> no data_valid, rd_data stays 0.
REQ-036 Scenario: reset asserted with 2 reads in flight -> no data_valid after release; with MEM_CLEAR_ON_RESET_EN defined, req_ready=0 for 1024 cycles and every word then reads 0.
